// File: rtl/pong_pkg.sv
// Shared constants for the pong button front end: debounce FSM encoding and
// default debounce / auto-repeat timing at a 100 MHz system clock.
package pong_pkg;

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    localparam int DB_CYCLES_DEF     = 1_000_000;   // 10 ms
    localparam int REPEAT_DELAY_DEF  = 50_000_000;  // 500 ms
    localparam int REPEAT_PERIOD_DEF = 10_000_000;  // 100 ms

    // Counter width for a count of n cycles, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and auto-repeat
// generator. All outputs are registered; press_next feeds the shared any_press flop.
module btn_channel
    import pong_pkg::*;
#(
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic press_next
);

    localparam int DB_W    = cnt_width(DB_CYCLES);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = cnt_width(RPT_MAX);

    localparam logic [DB_W-1:0]  DB_LAST      = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [1:0]       sync_reg;
    logic [1:0]       state_reg,     state_next;
    logic [DB_W-1:0]  db_cnt_reg,    db_cnt_next;
    logic [RPT_W-1:0] rpt_cnt_reg,   rpt_cnt_next;
    logic             rpt_first_reg, rpt_first_next;
    logic             level_reg,     level_next;
    logic             press_reg;
    logic             release_reg,   release_next;
    logic             sync_in;

    assign sync_in = sync_reg[1];

    always_comb begin
        state_next     = state_reg;
        db_cnt_next    = db_cnt_reg;
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_first_next = rpt_first_reg;
        level_next     = level_reg;
        press_next     = 1'b0;
        release_next   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sync_in) begin
                    state_next  = ST_WAIT_PRESS;
                    db_cnt_next = '0;
                end
            end
            ST_WAIT_PRESS: begin
                if (!sync_in) begin
                    state_next = ST_IDLE;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next = ST_PRESSED;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!sync_in) begin
                    state_next  = ST_WAIT_RELEASE;
                    db_cnt_next = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (sync_in) begin
                    state_next = ST_PRESSED;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next   = ST_IDLE;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    db_cnt_next = db_cnt_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Repeat timer runs only while the channel stays in PRESSED; the first
        // interval is measured from the original press pulse.
        if (state_reg == ST_PRESSED && sync_in && repeat_en) begin
            if (rpt_cnt_reg == (rpt_first_reg ? RPT_DLY_LAST : RPT_PER_LAST)) begin
                press_next     = 1'b1;
                rpt_cnt_next   = '0;
                rpt_first_next = 1'b0;
            end else begin
                rpt_cnt_next = rpt_cnt_reg + 1'b1;
            end
        end else begin
            rpt_cnt_next   = '0;
            rpt_first_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg      <= '0;
            state_reg     <= ST_IDLE;
            db_cnt_reg    <= '0;
            rpt_cnt_reg   <= '0;
            rpt_first_reg <= 1'b1;
            level_reg     <= 1'b0;
            press_reg     <= 1'b0;
            release_reg   <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], btn_raw};
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            rpt_cnt_reg   <= rpt_cnt_next;
            rpt_first_reg <= rpt_first_next;
            level_reg     <= level_next;
            press_reg     <= press_next;
            release_reg   <= release_next;
        end
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: NCH independent debounce/repeat channels
// plus a registered any_press flag aligned with the btn_press pulses.
module btn_conditioner
    import pong_pkg::*;
#(
    parameter int NCH           = 2,
    parameter int DB_CYCLES     = DB_CYCLES_DEF,
    parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] btn_raw,
    input  logic           repeat_en,
    output logic [NCH-1:0] btn_level,
    output logic [NCH-1:0] btn_press,
    output logic [NCH-1:0] btn_release,
    output logic           any_press
);

    logic [NCH-1:0] press_next;
    logic           any_press_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            btn_channel #(
                .DB_CYCLES     (DB_CYCLES),
                .REPEAT_DELAY  (REPEAT_DELAY),
                .REPEAT_PERIOD (REPEAT_PERIOD)
            ) u_ch (
                .clk         (clk),
                .reset       (reset),
                .btn_raw     (btn_raw[gi]),
                .repeat_en   (repeat_en),
                .btn_level   (btn_level[gi]),
                .btn_press   (btn_press[gi]),
                .btn_release (btn_release[gi]),
                .press_next  (press_next[gi])
            );
        end
    endgenerate

    // Registered from the channels' next-press terms so it lines up with btn_press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            any_press_reg <= 1'b0;
        end else begin
            any_press_reg <= |press_next;
        end
    end

    assign any_press = any_press_reg;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with short debounce/repeat timing:
// expected pulse events are queued when stimulus is driven, checked as they appear.
module tb_btn_conditioner;

    localparam int NCH = 2;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;

    logic           clk       = 1'b0;
    logic           reset     = 1'b0;
    logic           repeat_en = 1'b0;
    logic [NCH-1:0] btn_raw   = '0;
    logic [NCH-1:0] btn_level;
    logic [NCH-1:0] btn_press;
    logic [NCH-1:0] btn_release;
    logic           any_press;

    typedef struct {
        int         cyc;
        logic [1:0] press;
        logic [1:0] rel;
        logic       any;
    } ev_t;

    ev_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    btn_conditioner #(
        .NCH           (NCH),
        .DB_CYCLES     (DB),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .any_press   (any_press)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic expect_ev(input int c, input logic [1:0] p, input logic [1:0] r, input logic a);
        ev_t e;
        e.cyc   = c;
        e.press = p;
        e.rel   = r;
        e.any   = a;
        sb.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Drive at a falling edge; e is the first rising edge that samples the new value.
    task automatic drive(input logic [1:0] v, output int e);
        @(negedge clk);
        btn_raw = v;
        e = cyc + 1;
    endtask

    // Monitor: every pulse cycle must match the next queued event.
    always @(negedge clk) begin
        ev_t e;
        if (reset && ((|btn_press) || (|btn_release) || any_press)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", {27'd0, btn_press, btn_release, any_press}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ev_cycle", cyc, e.cyc);
                check("ev_press", {30'd0, btn_press}, {30'd0, e.press});
                check("ev_release", {30'd0, btn_release}, {30'd0, e.rel});
                check("ev_any", {31'd0, any_press}, {31'd0, e.any});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, p;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_level", {30'd0, btn_level}, 32'd0);
        check("rst_press", {30'd0, btn_press}, 32'd0);
        check("rst_release", {30'd0, btn_release}, 32'd0);
        check("rst_any", {31'd0, any_press}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        wait_to(cyc + 3);

        // Clean press and release on channel 0
        drive(2'b01, e);
        expect_ev(e + 6, 2'b01, 2'b00, 1'b1);
        wait_to(e + 5);
        check("press_lvl_before", {30'd0, btn_level}, 32'd0);
        wait_to(e + 6);
        check("press_lvl_at", {30'd0, btn_level}, 32'd1);
        wait_to(e + 12);
        drive(2'b00, e);
        expect_ev(e + 6, 2'b00, 2'b01, 1'b0);
        wait_to(e + 5);
        check("rel_lvl_before", {30'd0, btn_level}, 32'd1);
        wait_to(e + 6);
        check("rel_lvl_at", {30'd0, btn_level}, 32'd0);
        wait_to(e + 12);

        // Bouncing press on channel 1: 1,1,0,0 then held 1
        drive(2'b10, e);
        drive(2'b10, t);
        drive(2'b00, t);
        drive(2'b00, t);
        drive(2'b10, t);
        expect_ev(t + 6, 2'b10, 2'b00, 1'b1);
        wait_to(t + 6);
        check("bounce_lvl", {30'd0, btn_level}, 32'd2);
        wait_to(t + 10);
        drive(2'b00, e);
        expect_ev(e + 6, 2'b00, 2'b10, 1'b0);
        wait_to(e + 12);

        // 3-cycle glitch on channel 0: no output activity at all
        drive(2'b01, e);
        drive(2'b01, t);
        drive(2'b01, t);
        drive(2'b00, t);
        wait_to(e + 15);
        check("glitch_lvl", {30'd0, btn_level}, 32'd0);

        // Auto-repeat on channel 0, then disable repeat while still held
        repeat_en = 1'b1;
        drive(2'b01, e);
        p = e + 6;
        expect_ev(p, 2'b01, 2'b00, 1'b1);
        for (int k = 0; k < 5; k++) expect_ev(p + RD + k * RP, 2'b01, 2'b00, 1'b1);
        wait_to(p + 54);
        repeat_en = 1'b0;
        wait_to(p + 70);
        check("repeat_lvl_held", {30'd0, btn_level}, 32'd1);
        drive(2'b00, e);
        expect_ev(e + 6, 2'b00, 2'b01, 1'b0);
        wait_to(e + 10);

        // Simultaneous press on both channels
        drive(2'b11, e);
        expect_ev(e + 6, 2'b11, 2'b00, 1'b1);
        wait_to(e + 7);
        check("sim_any_single", {31'd0, any_press}, 32'd0);
        check("sim_lvl", {30'd0, btn_level}, 32'd3);
        wait_to(e + 10);
        drive(2'b00, e);
        expect_ev(e + 6, 2'b00, 2'b11, 1'b0);
        wait_to(e + 10);

        // Reset while channel 0 is held: level drops with no release pulse
        drive(2'b01, e);
        expect_ev(e + 6, 2'b01, 2'b00, 1'b1);
        wait_to(e + 10);
        check("rst_mid_lvl_before", {30'd0, btn_level}, 32'd1);
        #2 reset = 1'b0;
        #1 check("rst_mid_lvl_async", {30'd0, btn_level}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        e = cyc + 1;
        expect_ev(e + 6, 2'b01, 2'b00, 1'b1);
        wait_to(e + 5);
        check("rst_rel_lvl_before", {30'd0, btn_level}, 32'd0);
        wait_to(e + 6);
        check("rst_rel_lvl_at", {30'd0, btn_level}, 32'd1);
        wait_to(e + 10);
        drive(2'b00, e);
        expect_ev(e + 6, 2'b00, 2'b01, 1'b0);
        wait_to(e + 12);

        check("sb_left", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 Parameter NCH, default 2, number of button channels.
REQ-002 Parameter DB_CYCLES, default 1_000_000, stable cycles required to accept a level change (10 ms at 100 MHz); legal range is 2 or more.
REQ-003 Parameter REPEAT_DELAY, default 50_000_000, hold cycles from press pulse to first repeat pulse.
REQ-004 Parameter REPEAT_PERIOD, default 10_000_000, cycles between subsequent repeat pulses.
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 reset  input  1  reset; one clock, asynchronous, active-low (asserted when 0).
REQ-007 btn_raw  input  NCH  raw, asynchronous, bouncing push-button levels; 1 means pressed.
REQ-008 repeat_en  input  1  enables auto-repeat press pulses on held buttons.
REQ-009 btn_level  output  NCH  debounced level; this output drives the game FSM btn bus.
REQ-010 btn_press  output  NCH  one-cycle pulse on an accepted press, or on a repeat.
REQ-011 btn_release  output  NCH  one-cycle pulse on an accepted release.
REQ-012 any_press  output  1  OR of btn_press, in the same cycle.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other logic uses it.
REQ-014 Each channel SHALL run an independent FSM with the states IDLE, WAIT_PRESS, PRESSED and WAIT_RELEASE.
REQ-015 In IDLE, a synchronized 1 SHALL move the FSM to WAIT_PRESS and clear the stability counter.
REQ-016 In WAIT_PRESS, a synchronized 0 SHALL return the FSM to IDLE.
REQ-017 In WAIT_PRESS, once the counter reaches DB_CYCLES-1, the FSM SHALL go to PRESSED and set btn_level to 1.
REQ-018 The btn_press pulse SHALL assert in the same cycle that btn_level rises.
REQ-019 PRESSED and WAIT_RELEASE SHALL mirror REQ-015 to REQ-017 for 0 inputs; on entry to IDLE, btn_level SHALL fall and btn_release SHALL pulse in that same cycle.
REQ-020 Latency: with btn_raw held steady after an edge, btn_level SHALL change exactly DB_CYCLES+2 clocks after that edge.
REQ-021 Glitch rejection: any raw pulse or dropout shorter than DB_CYCLES cycles SHALL produce no change on any output.
REQ-022 Auto-repeat timing: in PRESSED with repeat_en=1, btn_press SHALL pulse REPEAT_DELAY cycles after the original press pulse, then every REPEAT_PERIOD cycles while the channel stays in PRESSED.
REQ-023 Auto-repeat stop: the repeat counter SHALL clear when the channel leaves PRESSED or when repeat_en=0.
REQ-024 Repeat pulses SHALL NOT affect btn_level.
REQ-025 Channels SHALL be fully independent; simultaneous presses SHALL pulse in the same cycle, and any_press SHALL stay a single-cycle pulse.
REQ-026 Counters SHALL saturate and never wrap; counter widths SHALL be clog2 of the respective parameter.
REQ-027 Every output SHALL be registered, with no combinational path from btn_raw to any output.

Reset
REQ-028 With reset=0, all outputs, synchronizers, counters and FSMs SHALL clear immediately (FSM to IDLE), asynchronously.
REQ-029 Reset mid-operation SHALL drop btn_level without a btn_release pulse.
REQ-030 A button held through reset release SHALL be treated as a new press, with btn_level rising DB_CYCLES+2 cycles after reset deasserts.

Structure
REQ-031 The FSM state encoding and the default DB/REPEAT constants SHALL reside in the shared package pong_pkg.
REQ-032 The single-channel logic SHALL be a sub-module btn_channel, instantiated NCH times by a generate loop.

Verification (DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-033 Clean press: btn_raw[0] 0->1 at cycle 0 and held -> btn_level[0]=1 and btn_press[0] pulse at cycle 6; any_press pulses at cycle 6.
REQ-034 Bounce: btn_raw[1] toggles 1,0,1 with 2-cycle spacing, then holds at 1 -> exactly one btn_press[1], arriving 6 cycles after the final rising edge.
REQ-035 Glitch: a 3-cycle high pulse on btn_raw[0] -> all outputs stay 0.
REQ-036 Repeat: with repeat_en=1 and btn_raw[0] held for 60 cycles -> btn_press[0] at press+0, +20, +28, +36, ...; clearing repeat_en stops the pulses and btn_level[0] stays 1.
REQ-037 Simultaneous: both buttons rise in the same cycle -> both btn_press bits pulse in one cycle, and any_press is high for exactly 1 cycle.
REQ-038 Reset mid-hold: reset asserted while btn_level[0]=1 -> btn_level[0]=0 with no btn_release; after reset release with the button still held, btn_press[0] pulses 6 cycles later.
